branch_resolve_unit: RTL and testbench

- Execute-stage branch resolver; the back end of the fetch-side branch-address select.
- Fetch speculatively steers to the target on every conditional branch, i.e. static predict-taken.
- This block:
  - evaluates the real condition and computes JAL/JALR targets;
  - drives the registered branch-outcome flag (`branch_true`) back to fetch;
  - issues a redirect plus a timed front-end flush when fetch went the wrong way.

---
 rtl/branch_resolve_unit.sv | 161 ++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: checks predict-taken conditional branches, computes JAL/JALR targets, and issues a redirect with a timed front-end flush.
// Optional mispredict counter is enabled with `define BRU_PERF_CNT_EN.
module branch_resolve_unit #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [31:0]     ex_inst,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            stall,
  output logic            branch_true,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            busy
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] mispredict_count
`endif
);

  // Handshake: an instruction is consumed on a rising edge when ex_valid is high,
  // stall is low and the unit is IDLE; there is no back-pressure beyond stall/busy.

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            bt_q, bt_d;
  logic            rv_q, rv_d;
  logic [XLEN-1:0] rpc_q, rpc_d;
  logic            flush_q, flush_d;
  logic            busy_q, busy_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            cond_taken;
  logic            capture;
  logic            is_cond, is_jal, is_jalr;
  logic            need_redirect;
  logic            cond_miss;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;

  logic unused_inst_bits;
  assign unused_inst_bits = ^{ex_inst[31:15], ex_inst[11:7]};

  always_comb begin
    opcode   = ex_inst[6:0];
    funct3   = ex_inst[14:12];
    is_cond  = (opcode == OP_BRANCH);
    is_jal   = (opcode == OP_JAL);
    is_jalr  = (opcode == OP_JALR);
    capture  = ex_valid && !stall && (state_q == S_IDLE);

    cond_taken = 1'b0;
    case (funct3)
      3'b000:  cond_taken = (rs1_val == rs2_val);
      3'b001:  cond_taken = (rs1_val != rs2_val);
      3'b100:  cond_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  cond_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  cond_taken = (rs1_val <  rs2_val);
      3'b111:  cond_taken = (rs1_val >= rs2_val);
      default: cond_taken = 1'b0;
    endcase

    cond_miss     = capture && is_cond && !cond_taken;
    need_redirect = cond_miss || (capture && (is_jal || is_jalr));

    jalr_sum = rs1_val + ex_imm;
    if (is_jal)       target = ex_pc + ex_imm;
    else if (is_jalr) target = {jalr_sum[XLEN-1:1], 1'b0};
    else              target = ex_pc + XLEN'(4);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bt_d    = bt_q;
    rpc_d   = rpc_q;
    rv_d    = 1'b0;
    flush_d = 1'b0;
    busy_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (capture && is_cond) bt_d = cond_taken;
        if (need_redirect) begin
          rv_d    = 1'b1;
          flush_d = 1'b1;
          rpc_d   = target;
          cnt_d   = FLUSH_INIT;
          state_d = (FLUSH_CYCLES > 1) ? S_FLUSH : S_IDLE;
        end
      end
      S_FLUSH: begin
        // Wrong-path instructions are ignored; the countdown ignores stall.
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          flush_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      bt_q    <= 1'b0;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
      flush_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bt_q    <= bt_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
      flush_q <= flush_d;
      busy_q  <= busy_d;
    end
  end

  assign branch_true    = bt_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign flush_if_id    = flush_q;
  assign flush_id_ex    = flush_q;
  assign busy           = busy_q;

`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] mcnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         mcnt_q <= '0;
    else if (cond_miss && !(&mcnt_q))   mcnt_q <= mcnt_q + CNT_W'(1);
  end
  assign mispredict_count = mcnt_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_branch_resolve_unit;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_inst, ex_pc, rs1_val, rs2_val, ex_imm;
  logic        stall;
  logic        branch_true, redirect_valid, flush_if_id, flush_id_ex, busy;
  logic [31:0] redirect_pc;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] mispredict_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic        m_bt, m_rv;
  logic [31:0] m_pc;
  int          m_flush_left;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(FC), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_inst(ex_inst),
    .ex_pc(ex_pc), .rs1_val(rs1_val), .rs2_val(rs2_val), .ex_imm(ex_imm),
    .stall(stall), .branch_true(branch_true), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .busy(busy)
`ifdef BRU_PERF_CNT_EN
    , .mispredict_count(mispredict_count)
`endif
  );

  function automatic logic [31:0] br(input logic [2:0] f3);
    logic [31:0] w;
    w = 32'h0;
    w[14:12] = f3;
    w[6:0] = 7'b1100011;
    return w;
  endfunction

  localparam logic [31:0] JAL_I  = 32'h0000_006F;
  localparam logic [31:0] JALR_I = 32'h0000_0067;
  localparam logic [31:0] NOP_I  = 32'h0000_0013;

  task automatic model_reset();
    m_bt = 0; m_rv = 0; m_pc = 0; m_flush_left = 0; m_cnt = 0;
  endtask

  // Advance the model by one rising edge using the inputs held across it.
  task automatic model_step();
    logic taken;
    m_rv = 0;
    if (m_flush_left > 0) begin
      m_flush_left = m_flush_left - 1;
    end else if (ex_valid && !stall) begin
      if (ex_inst[6:0] == 7'b1100011) begin
        case (ex_inst[14:12])
          3'd0: taken = rs1_val == rs2_val;
          3'd1: taken = rs1_val != rs2_val;
          3'd4: taken = (rs1_val ^ 32'h8000_0000) <  (rs2_val ^ 32'h8000_0000);
          3'd5: taken = (rs1_val ^ 32'h8000_0000) >= (rs2_val ^ 32'h8000_0000);
          3'd6: taken = rs1_val <  rs2_val;
          3'd7: taken = rs1_val >= rs2_val;
          default: taken = 0;
        endcase
        m_bt = taken;
        if (!taken) begin
          m_rv = 1; m_pc = ex_pc + 32'd4; m_flush_left = FC;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
      end else if (ex_inst[6:0] == 7'b1101111) begin
        m_rv = 1; m_pc = ex_pc + ex_imm; m_flush_left = FC;
      end else if (ex_inst[6:0] == 7'b1100111) begin
        m_rv = 1; m_pc = (rs1_val + ex_imm) & ~32'd1; m_flush_left = FC;
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [31:0] i, p, a, b, m, input logic s);
    @(negedge clk);
    ex_valid = v; ex_inst = i; ex_pc = p; rs1_val = a; rs2_val = b; ex_imm = m; stall = s;
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, NOP_I, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 0; ex_valid = 0; ex_inst = 0; ex_pc = 0; rs1_val = 0; rs2_val = 0; ex_imm = 0; stall = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({branch_true, redirect_valid, flush_if_id, flush_id_ex, busy} !== 5'b0 || redirect_pc !== 32'h0) begin
      n_err++;
      $display("FAIL reset: bt=%b rv=%b fi=%b fe=%b busy=%b pc=%h, want all 0",
               branch_true, redirect_valid, flush_if_id, flush_id_ex, busy, redirect_pc);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_conditional();
    cycle(1'b1, br(3'd0), 32'h100, 32'd5, 32'd5, 32'h20, 1'b0);
    n_vec++;
    if ({branch_true, redirect_valid, flush_if_id, flush_id_ex} !== 4'b1000) begin
      n_err++;
      $display("FAIL beq_taken: bt/rv/fi/fe=%b want 1000", {branch_true, redirect_valid, flush_if_id, flush_id_ex});
    end
    cycle(1'b1, br(3'd1), 32'h200, 32'd7, 32'd7, 32'h20, 1'b0);
    n_vec++;
    if ({branch_true, redirect_valid, flush_if_id, flush_id_ex, busy} !== 5'b01110 || redirect_pc !== 32'h204) begin
      n_err++;
      $display("FAIL bne_pulse: bt/rv/fi/fe/busy=%b pc=%h want 01110 pc=00000204",
               {branch_true, redirect_valid, flush_if_id, flush_id_ex, busy}, redirect_pc);
    end
    idle(1);
    n_vec++;
    if ({redirect_valid, flush_if_id, flush_id_ex, busy} !== 4'b0111) begin
      n_err++;
      $display("FAIL bne_flush2: rv/fi/fe/busy=%b want 0111", {redirect_valid, flush_if_id, flush_id_ex, busy});
    end
    idle(1);
    n_vec++;
    if ({redirect_valid, flush_if_id, flush_id_ex, busy} !== 4'b0000 || redirect_pc !== 32'h204) begin
      n_err++;
      $display("FAIL bne_done: rv/fi/fe/busy=%b pc=%h want 0000 pc=00000204",
               {redirect_valid, flush_if_id, flush_id_ex, busy}, redirect_pc);
    end
    cycle(1'b1, br(3'd4), 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0);
    n_vec++;
    if (branch_true !== 1'b1 || redirect_valid !== 1'b0) begin
      n_err++;
      $display("FAIL blt_signed: bt=%b rv=%b want 1 0", branch_true, redirect_valid);
    end
    cycle(1'b1, br(3'd6), 32'h304, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0);
    n_vec++;
    if (branch_true !== 1'b0 || redirect_valid !== 1'b1 || redirect_pc !== 32'h308) begin
      n_err++;
      $display("FAIL bltu_unsigned: bt=%b rv=%b pc=%h want 0 1 00000308", branch_true, redirect_valid, redirect_pc);
    end
    idle(2);
  endtask

  task automatic test_jumps();
    cycle(1'b1, JALR_I, 32'h500, 32'h1003, 32'h0, 32'h10, 1'b0);
    n_vec++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1012 || branch_true !== m_bt) begin
      n_err++;
      $display("FAIL jalr: rv=%b pc=%h bt=%b want 1 00001012 bt=%b", redirect_valid, redirect_pc, branch_true, m_bt);
    end
    idle(2);
    cycle(1'b1, JAL_I, 32'hFFFF_FFF0, 32'h0, 32'h0, 32'h20, 1'b0);
    n_vec++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h10) begin
      n_err++;
      $display("FAIL jal_wrap: rv=%b pc=%h want 1 00000010", redirect_valid, redirect_pc);
    end
    idle(2);
  endtask

  task automatic test_flush_ignore();
    cycle(1'b1, br(3'd0), 32'h600, 32'd1, 32'd2, 32'h8, 1'b0);
    cycle(1'b1, br(3'd0), 32'h604, 32'd3, 32'd3, 32'h8, 1'b0);
    n_vec++;
    if (branch_true !== 1'b0 || redirect_valid !== 1'b0 || flush_if_id !== 1'b1) begin
      n_err++;
      $display("FAIL flush_ignore: bt=%b rv=%b fi=%b want 0 0 1", branch_true, redirect_valid, flush_if_id);
    end
    idle(2);
    cycle(1'b1, br(3'd1), 32'h700, 32'd4, 32'd4, 32'h8, 1'b0);
    #2;
    rst_n = 0;
    #1;
    n_vec++;
    if ({branch_true, redirect_valid, flush_if_id, flush_id_ex, busy} !== 5'b0 || redirect_pc !== 32'h0) begin
      n_err++;
      $display("FAIL reset_midflush: bt/rv/fi/fe/busy=%b pc=%h want 00000 0",
               {branch_true, redirect_valid, flush_if_id, flush_id_ex, busy}, redirect_pc);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    idle(1);
  endtask

  task automatic test_stall();
    int pulses;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, br(3'd1), 32'h800, 32'd9, 32'd9, 32'h8, 1'b1);
      if (redirect_valid === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL stall_hold: pulses=%0d want 0", pulses);
    end
    cycle(1'b1, br(3'd1), 32'h800, 32'd9, 32'd9, 32'h8, 1'b0);
    if (redirect_valid === 1'b1) pulses++;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, NOP_I, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      if (redirect_valid === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses !== 1 || redirect_pc !== 32'h804) begin
      n_err++;
      $display("FAIL stall_release: pulses=%0d pc=%h want 1 00000804", pulses, redirect_pc);
    end
  endtask

`ifdef BRU_PERF_CNT_EN
  task automatic test_perf();
    test_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, br(3'd0), 32'h900 + 32'(k * 16), 32'd1, 32'd2, 32'h8, 1'b0);
      idle(2);
    end
    cycle(1'b1, JAL_I, 32'hA00, 32'h0, 32'h0, 32'h40, 1'b0);
    idle(2);
    n_vec++;
    if (mispredict_count !== 32'd3) begin
      n_err++;
      $display("FAIL perf_count: got %0d want 3", mispredict_count);
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] ops[4];
    logic [31:0] i, a, b;
    ops[0] = br(3'd0); ops[1] = JAL_I; ops[2] = JALR_I; ops[3] = NOP_I;
    for (int k = 0; k < 400; k++) begin
      i = ops[$urandom_range(0, 3)];
      if (i[6:0] == 7'b1100011) i[14:12] = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) begin a = 32'($urandom_range(0, 4)); b = 32'($urandom_range(0, 4)); end
      cycle(1'($urandom_range(0, 4) != 0), i, $urandom, a, b, $urandom,
            1'($urandom_range(0, 5) == 0));
      n_vec++;
      if (branch_true !== m_bt || redirect_valid !== m_rv || redirect_pc !== m_pc ||
          flush_if_id !== (m_flush_left > 0) || flush_id_ex !== (m_flush_left > 0) ||
          busy !== ((m_flush_left > 0) && !m_rv)) begin
        n_err++;
        $display("FAIL random[%0d]: bt=%b rv=%b pc=%h fi=%b fe=%b busy=%b want bt=%b rv=%b pc=%h fl=%b busy=%b",
                 k, branch_true, redirect_valid, redirect_pc, flush_if_id, flush_id_ex, busy,
                 m_bt, m_rv, m_pc, (m_flush_left > 0), ((m_flush_left > 0) && !m_rv));
      end
`ifdef BRU_PERF_CNT_EN
      n_vec++;
      if (mispredict_count !== m_cnt) begin
        n_err++;
        $display("FAIL random_cnt[%0d]: got %0d want %0d", k, mispredict_count, m_cnt);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_conditional();
    test_jumps();
    test_flush_ignore();
    test_stall();
    test_random();
`ifdef BRU_PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
